// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared defaults and the occupancy-counter width helper
// for the elastic register pipeline.
package reg_pipe_pkg;

   localparam int REG_PIPE_WIDTH_DEF = 8;
   localparam int REG_PIPE_DEPTH_DEF = 2;

   // Bits needed to hold an occupancy in the range 0..depth inclusive.
   function automatic int reg_pipe_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one elastic stage. It holds a valid bit and a data word.
// It loads from its upstream neighbour whenever it is empty or its
// downstream neighbour can take its current content.
// The clear input drops the valid bit and keeps the data register as it is.
module reg_pipe_stage #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic             rdy_next,
   input  logic             clear,
   output logic             rdy,
   output logic             v_o,
   output logic [WIDTH-1:0] d_o
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // The stage can take a beat when it is empty or its content moves on.
   assign rdy = !v_q || rdy_next;
   assign v_o = v_q;
   assign d_o = d_q;

   // Next state: clear beats load; data is only written for a valid beat.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clear) begin
         v_d = 1'b0;
      end else if (rdy) begin
         v_d = v_in;
         if (v_in) begin
            d_d = d_in;
         end
      end
   end

   // Stage registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q <= 1'b0;
         d_q <= RESET_VAL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage elastic register pipeline with valid/ready
// backpressure and bubble collapse.
// The optional flush input is enabled by defining REG_PIPE_FLUSH_EN.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = REG_PIPE_WIDTH_DEF,
   parameter int               DEPTH     = REG_PIPE_DEPTH_DEF,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              s_valid,
   input  logic [WIDTH-1:0]                  s_data,
   output logic                              s_ready,
   output logic                              m_valid,
   output logic [WIDTH-1:0]                  m_data,
   input  logic                              m_ready,
   output logic [reg_pipe_cnt_w(DEPTH)-1:0]  count
`ifdef REG_PIPE_FLUSH_EN
   ,
   input  logic                              flush
`endif
);

   localparam int CW = reg_pipe_cnt_w(DEPTH);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] d [DEPTH];
   logic             flush_int;
   logic [CW-1:0]    count_d;

`ifdef REG_PIPE_FLUSH_EN
   assign flush_int = flush;
`else
   assign flush_int = 1'b0;
`endif

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             v_src;
         logic [WIDTH-1:0] d_src;
         logic             rdy_dn;

         if (gi == 0) begin : g_first
            assign v_src = s_valid;
            assign d_src = s_data;
         end else begin : g_mid
            assign v_src = v[gi-1];
            assign d_src = d[gi-1];
         end

         if (gi == DEPTH - 1) begin : g_last
            assign rdy_dn = m_ready;
         end else begin : g_inner
            assign rdy_dn = rdy[gi+1];
         end

         reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .v_in     (v_src),
            .d_in     (d_src),
            .rdy_next (rdy_dn),
            .clear    (flush_int),
            .rdy      (rdy[gi]),
            .v_o      (v[gi]),
            .d_o      (d[gi])
         );
      end
   endgenerate

   assign s_ready = rdy[0] && !flush_int;
   assign m_valid = v[DEPTH-1];
   assign m_data  = d[DEPTH-1];
   assign count   = count_d;

   // Occupancy is the population count of the registered valid bits.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_d = count_d + CW'(v[i]);
      end
   end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed bench for reg_pipe. It uses three instances
// (DEPTH 2, 3 and 4) and a scoreboard queue per instance.
// Build with REG_PIPE_FLUSH_EN defined to exercise the flush port as well.
module tb_reg_pipe;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // DEPTH=2 instance
   logic       s_valid2 = 0, s_ready2, m_valid2, m_ready2 = 0;
   logic [7:0] s_data2 = 0, m_data2;
   logic [1:0] count2;
   // DEPTH=3 instance
   logic       s_valid3 = 0, s_ready3, m_valid3, m_ready3 = 0;
   logic [7:0] s_data3 = 0, m_data3;
   logic [1:0] count3;
   // DEPTH=4 instance
   logic       s_valid4 = 0, s_ready4, m_valid4, m_ready4 = 0;
   logic [7:0] s_data4 = 0, m_data4;
   logic [2:0] count4;

   logic flush2 = 0, flush3 = 0, flush4 = 0;

   logic [7:0] q2[$];
   logic [7:0] q3[$];
   logic [7:0] q4[$];

   reg_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h00)) u_p2 (
      .clk(clk), .reset(reset),
      .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
      .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2),
      .count(count2)
`ifdef REG_PIPE_FLUSH_EN
      , .flush(flush2)
`endif
   );

   reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_p3 (
      .clk(clk), .reset(reset),
      .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
      .m_valid(m_valid3), .m_data(m_data3), .m_ready(m_ready3),
      .count(count3)
`ifdef REG_PIPE_FLUSH_EN
      , .flush(flush3)
`endif
   );

   reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_p4 (
      .clk(clk), .reset(reset),
      .s_valid(s_valid4), .s_data(s_data4), .s_ready(s_ready4),
      .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready4),
      .count(count4)
`ifdef REG_PIPE_FLUSH_EN
      , .flush(flush4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push accepted beats and pop/compare delivered beats.
   // Sampling happens on the falling edge, ahead of the edge that transfers.
   always @(negedge clk) begin
      if (reset) begin
         q2.delete();
         q3.delete();
         q4.delete();
      end else begin
         if (m_valid2 && m_ready2) begin
            if (q2.size() == 0) chk("p2_unexpected_beat", 32'(m_data2), 32'hFFFF_FFFF);
            else begin
               chk("p2_out_data", 32'(m_data2), 32'(q2.pop_front()));
               $display("p2 out %02h", m_data2);
            end
         end
         if (s_valid2 && s_ready2) begin
            q2.push_back(s_data2);
            $display("p2 in  %02h", s_data2);
         end

         if (m_valid3 && m_ready3) begin
            if (q3.size() == 0) chk("p3_unexpected_beat", 32'(m_data3), 32'hFFFF_FFFF);
            else begin
               chk("p3_out_data", 32'(m_data3), 32'(q3.pop_front()));
               $display("p3 out %02h", m_data3);
            end
         end
         if (flush3) begin
            q3.delete();
         end else if (s_valid3 && s_ready3) begin
            q3.push_back(s_data3);
            $display("p3 in  %02h", s_data3);
         end

         if (m_valid4 && m_ready4) begin
            if (q4.size() == 0) chk("p4_unexpected_beat", 32'(m_data4), 32'hFFFF_FFFF);
            else begin
               chk("p4_out_data", 32'(m_data4), 32'(q4.pop_front()));
               $display("p4 out %02h", m_data4);
            end
         end
         if (s_valid4 && s_ready4) begin
            q4.push_back(s_data4);
            $display("p4 in  %02h", s_data4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) step();
      chk("rst_m_valid", 32'(m_valid2), 0);
      chk("rst_m_data", 32'(m_data2), 32'h00);
      chk("rst_count", 32'(count2), 0);
      chk("rst_s_ready", 32'(s_ready2), 1);
      reset = 1'b0;
      step();

      // Streaming through DEPTH=2 with m_ready held high
      m_ready2 = 1;
      s_valid2 = 1; s_data2 = 8'h01;
      step();
      chk("stream_lat_m_valid0", 32'(m_valid2), 0);
      chk("stream_s_ready", 32'(s_ready2), 1);
      s_data2 = 8'h02;
      step();
      chk("stream_m_valid1", 32'(m_valid2), 1);
      chk("stream_data1", 32'(m_data2), 32'h01);
      s_data2 = 8'h03;
      step();
      chk("stream_m_valid2", 32'(m_valid2), 1);
      chk("stream_data2", 32'(m_data2), 32'h02);
      s_valid2 = 0;
      step();
      chk("stream_m_valid3", 32'(m_valid2), 1);
      chk("stream_data3", 32'(m_data2), 32'h03);
      step();
      chk("stream_drained", 32'(m_valid2), 0);

      // Reset mid-stream with two beats in flight
      m_ready2 = 0;
      s_valid2 = 1; s_data2 = 8'h11;
      step();
      s_data2 = 8'h22;
      step();
      chk("midrst_count_before", 32'(count2), 2);
      s_data2 = 8'h33;
      #2 reset = 1'b1;
      #1;
      chk("midrst_m_valid", 32'(m_valid2), 0);
      chk("midrst_m_data", 32'(m_data2), 32'h00);
      chk("midrst_count", 32'(count2), 0);
      chk("midrst_s_ready", 32'(s_ready2), 1);
      step();
      chk("midrst_no_accept", 32'(count2), 0);
      reset = 1'b0;
      s_valid2 = 0;
      step();
      chk("postrst_count", 32'(count2), 0);

      // Stall and fill on DEPTH=3, then release
      m_ready3 = 0;
      s_valid3 = 1; s_data3 = 8'hA1;
      step();
      chk("fill_count1", 32'(count3), 1);
      s_data3 = 8'hA2;
      step();
      s_data3 = 8'hA3;
      step();
      s_data3 = 8'hA4;
      chk("fill_count3", 32'(count3), 3);
      chk("fill_s_ready_low", 32'(s_ready3), 0);
      chk("fill_head", 32'(m_data3), 32'hA1);
      step();
      chk("fill_hold_count", 32'(count3), 3);
      chk("fill_hold_s_ready", 32'(s_ready3), 0);
      m_ready3 = 1;
      #1;
      chk("full_sim_s_ready", 32'(s_ready3), 1);
      step();
      chk("full_sim_count", 32'(count3), 3);
      chk("full_sim_head", 32'(m_data3), 32'hA2);
      s_valid3 = 0;
      step();
      chk("drain_head3", 32'(m_data3), 32'hA3);
      step();
      chk("drain_head4", 32'(m_data3), 32'hA4);
      step();
      chk("drain_empty", 32'(m_valid3), 0);
      chk("drain_empty_s_ready", 32'(s_ready3), 1);
      m_ready3 = 0;

      // Bubble collapse on DEPTH=4
      m_ready4 = 0;
      s_valid4 = 1; s_data4 = 8'h55;
      step();
      s_valid4 = 0;
      chk("bubble_edge1_m_valid", 32'(m_valid4), 0);
      step();
      step();
      chk("bubble_edge3_m_valid", 32'(m_valid4), 0);
      step();
      chk("bubble_edge4_m_valid", 32'(m_valid4), 1);
      chk("bubble_edge4_m_data", 32'(m_data4), 32'h55);
      chk("bubble_count", 32'(count4), 1);
      chk("bubble_s_ready", 32'(s_ready4), 1);
      m_ready4 = 1;
      step();
      chk("bubble_drained", 32'(m_valid4), 0);
      m_ready4 = 0;

`ifdef REG_PIPE_FLUSH_EN
      // Flush with two beats resident
      s_valid3 = 1; s_data3 = 8'h61;
      step();
      s_data3 = 8'h62;
      step();
      chk("flush_count_before", 32'(count3), 2);
      flush3 = 1; s_data3 = 8'h77;
      #1;
      chk("flush_s_ready", 32'(s_ready3), 0);
      step();
      flush3 = 0; s_valid3 = 0;
      chk("flush_count_after", 32'(count3), 0);
      chk("flush_m_valid", 32'(m_valid3), 0);
      step();
      chk("flush_no_accept", 32'(count3), 0);
`endif

      step();
      chk("sb_p2_empty", 32'(q2.size()), 0);
      chk("sb_p3_empty", 32'(q3.size()), 0);
      chk("sb_p4_empty", 32'(q4.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit registers with a per-stage valid bit and valid/ready backpressure. It replaces the plain 8-bit reset register wherever data must cross one or more register stages between handshaking producers and consumers, such as datapath retiming, I/O staging and long FPGA routes. Bubbles collapse, so a stalled output does not waste stages that are empty.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 2: number of register stages, ≥1.
- RESET_VAL, 0: value loaded into every data register on reset (WIDTH bits).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- s_valid  in  1  upstream beat present.
- s_data  in  WIDTH  upstream beat.
- s_ready  out  1  pipeline accepts the beat this cycle.
- m_valid  out  1  output beat present (valid of stage DEPTH-1).
- m_data  out  WIDTH  output beat (data of stage DEPTH-1).
- m_ready  in  1  downstream accepts the beat.
- count  out  $clog2(DEPTH+1)  number of valid stages (occupancy).
- flush  in  1  present only with REG_PIPE_FLUSH_EN.

## Operation
- Stage i holds v[i] and d[i]. Stage 0 is fed from s_*, and m_* is driven from stage DEPTH-1.
- Ready chain (combinational): rdy[DEPTH-1] = !v[DEPTH-1] || m_ready; rdy[i] = !v[i] || rdy[i+1]; s_ready = rdy[0].
- Stage i loads on the edge when rdy[i]: v[i] <= v_in, d[i] <= d_in. The source is stage i-1 for i>0, and s_valid/s_data for stage 0.
- d[i] is written only when v_in=1. When v_in=0 the data register holds its value and only v[i] clears.
- When rdy[i]=0 the stage holds d[i] and v[i] unchanged.
- A transfer occurs on a port only when valid && ready. Beats are never duplicated, dropped or reordered.
- count = popcount(v). It is registered-equivalent because it is derived from registered v only.
- Data is not modified. There is no arithmetic on the data path.
- Reset: all v=0 and all d=RESET_VAL, immediately and asynchronously. Outputs go to m_valid=0, m_data=RESET_VAL and count=0. s_ready=1 during and after reset.
- Reset mid-stream: all in-flight beats are lost. No beat is accepted on an edge where reset is high.

## Timing
- Latency: a beat accepted at edge N appears on m_* after edge N+DEPTH-1. It is visible DEPTH cycles after it was presented, provided there are no stalls.
- Throughput: 1 beat/cycle sustained while m_ready=1.
- s_ready depends combinationally on m_ready. This path is accepted; add a skid stage externally if timing requires it.
- Full: count=DEPTH and m_ready=0 give s_ready=0. Simultaneous m_ready=1 with full makes s_ready=1 in the same cycle, so a beat enters while one leaves and count stays at DEPTH.
- Empty: count=0 gives m_valid=0 and s_ready=1.
- Bubble collapse: with m_ready=0, a new beat advances until it reaches the first occupied stage.

## Configuration
- REG_PIPE_FLUSH_EN defined:
  - Adds the flush input.
  - While flush=1, s_ready is forced 0 and the next edge clears every v. Data registers hold their values.
  - Flush has priority over every load. Any m_valid/m_ready coincidence in that cycle still counts as a transfer.
- REG_PIPE_FLUSH_EN undefined: the port is absent and no flush logic is generated.

## Structure
- Package reg_pipe_pkg contains:
  - REG_PIPE_WIDTH_DEF=8 and REG_PIPE_DEPTH_DEF=2.
  - A function computing the count width, clog2(DEPTH+1).
- Sub-module reg_pipe_stage: one valid/data register with async reset, a load enable and a ready computation. It is instantiated DEPTH times in a generate loop.

## Test plan
- Reset: assert reset mid-cycle with 2 beats in flight → m_valid=0, m_data=8'h00 and count=0 immediately; s_ready=1.
- Streaming (DEPTH=2, m_ready=1): s_data 8'h01,8'h02,8'h03 on consecutive cycles → each appears on m_data 2 cycles later, back-to-back with no bubbles.
- Stall/fill (DEPTH=3, m_ready=0): send 8'hA1..8'hA4 → the first 3 are accepted, count=3, s_ready=0 and A4 is held by the source. Raise m_ready → the output order is A1,A2,A3,A4.
- Simultaneous at full: count=DEPTH with m_ready=1 and s_valid=1 → one beat out and one in on the same edge; count stays DEPTH.
- Bubble collapse (DEPTH=4, m_ready=0): one beat 8'h55 → after 4 edges it sits in stage 3 (m_valid=1, count=1); s_ready remains 1.
- Flush (REG_PIPE_FLUSH_EN): with count=2, pulse flush for one cycle → s_ready=0 that cycle and count=0 after the edge. A beat presented during flush is not accepted.
